// File: rtl/usb_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg
//   Shared definitions for the USB receive path: line-level encodings,
//   default bit-stuffing limit and the NRZI/unstuff stage state encoding.
// ---------------------------------------------------------------------------
package usb_rx_pkg;

  // Line levels as seen on the differential pair after the receiver.
  localparam logic LVL_K = 1'b0;
  localparam logic LVL_J = 1'b1;

  // Consecutive decoded 1s after which the transmitter inserts a 0.
  localparam int STUFF_LIMIT_DFLT = 6;

  // Delivered-bit counter width; covers the longest data payload.
  localparam int CNT_W_DFLT = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERR
  } rc_nrzi_state_t;

endpackage

// File: rtl/rc_nrzi_unstuff_if.sv
// ---------------------------------------------------------------------------
// rc_nrzi_unstuff_if
//   Bundle between the SYNC/EOP receiver (line side), the NRZI decode /
//   unstuff stage, and the packet shift/CRC stage (data side).
//   Line side : abort, start_rc_nrzi, end_rc_nrzi, dpdm_error, s_in
//   Data side : d_out, d_valid, pkt_start, pkt_end, stuff_error, bit_count
//   modport master : the environment driving the line side
//   modport slave  : the decode/unstuff stage
// ---------------------------------------------------------------------------
interface rc_nrzi_unstuff_if
  import usb_rx_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
);

  logic             abort;
  logic             start_rc_nrzi;
  logic             end_rc_nrzi;
  logic             dpdm_error;
  logic             s_in;

  logic             d_out;
  logic             d_valid;
  logic             pkt_start;
  logic             pkt_end;
  logic             stuff_error;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output abort, start_rc_nrzi, end_rc_nrzi, dpdm_error, s_in,
    input  d_out, d_valid, pkt_start, pkt_end, stuff_error, bit_count
  );

  modport slave (
    input  abort, start_rc_nrzi, end_rc_nrzi, dpdm_error, s_in,
    output d_out, d_valid, pkt_start, pkt_end, stuff_error, bit_count
  );

endinterface

// File: rtl/rc_nrzi_unstuff_counter.sv
// ---------------------------------------------------------------------------
// rc_nrzi_unstuff_counter
//   Plain up-counter with synchronous clear (priority) and enable.
//   Saturation, if wanted, is the caller's job via en.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero
//   en         : increment by one
//   q          : count value
// ---------------------------------------------------------------------------
module rc_nrzi_unstuff_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/rc_nrzi_unstuff.sv
// ---------------------------------------------------------------------------
// rc_nrzi_unstuff
//   Receive-path stage after the SYNC/EOP receiver. Takes one line bit per
//   clk between start_rc_nrzi and end_rc_nrzi, NRZI-decodes it (no line
//   transition = 1), drops the stuffed 0 that follows STUFF_LIMIT ones and
//   flags a stuffing violation when that 0 is missing. All outputs are
//   registered, one clk after the input that caused them.
//   clk, rst_n : bit clock, async active-low reset
//   bus        : rc_nrzi_unstuff_if.slave (line-side inputs, data-side outputs)
// ---------------------------------------------------------------------------
module rc_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DFLT,
  parameter int CNT_W       = CNT_W_DFLT
) (
  input  logic                clk,
  input  logic                rst_n,
  rc_nrzi_unstuff_if.slave    bus
);

  localparam logic [2:0] ONES_LIMIT = 3'(STUFF_LIMIT);

  rc_nrzi_state_t   state, state_d;
  logic             prev_lvl, prev_lvl_d;
  logic [2:0]       ones_cnt, ones_cnt_d;

  logic             d_out_q, d_out_d;
  logic             d_valid_q, d_valid_d;
  logic             pkt_start_q, pkt_start_d;
  logic             pkt_end_q, pkt_end_d;
  logic             stuff_error_q, stuff_error_d;

  logic             load;
  logic             dec;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] bit_count;

  // A new packet is accepted from IDLE or (as a restart) from ACTIVE;
  // ERR only leaves through abort, and abort beats everything.
  assign load = ~bus.abort & bus.start_rc_nrzi & (state != ERR);

  // NRZI: a repeated level decodes to 1, a transition to 0.
  assign dec = ~(bus.s_in ^ prev_lvl);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state;
    prev_lvl_d    = prev_lvl;
    ones_cnt_d    = ones_cnt;
    d_out_d       = 1'b0;
    d_valid_d     = 1'b0;
    pkt_start_d   = 1'b0;
    pkt_end_d     = 1'b0;
    stuff_error_d = stuff_error_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    if (bus.abort) begin
      state_d       = IDLE;
      prev_lvl_d    = LVL_K;
      ones_cnt_d    = '0;
      stuff_error_d = 1'b0;
      cnt_clr       = 1'b1;
    end else if (load) begin
      // The last SYNC bit is a K and decodes as the packet's first 1.
      state_d     = ACTIVE;
      prev_lvl_d  = LVL_K;
      ones_cnt_d  = 3'd1;
      pkt_start_d = 1'b1;
      cnt_clr     = 1'b1;
    end else begin
      case (state)
        ACTIVE: begin
          if (bus.dpdm_error) begin
            state_d = IDLE;
          end else if (bus.end_rc_nrzi) begin
            state_d   = IDLE;
            pkt_end_d = 1'b1;
          end else begin
            prev_lvl_d = bus.s_in;
            if (ones_cnt == ONES_LIMIT) begin
              if (dec) begin
                state_d       = ERR;
                stuff_error_d = 1'b1;
              end else begin
                ones_cnt_d = '0;
              end
            end else begin
              d_out_d    = dec;
              d_valid_d  = 1'b1;
              cnt_inc    = 1'b1;
              ones_cnt_d = dec ? ones_cnt + 3'd1 : 3'd0;
            end
          end
        end
        IDLE, ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state elements use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      prev_lvl      <= LVL_K;
      ones_cnt      <= '0;
      d_out_q       <= 1'b0;
      d_valid_q     <= 1'b0;
      pkt_start_q   <= 1'b0;
      pkt_end_q     <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      state         <= state_d;
      prev_lvl      <= prev_lvl_d;
      ones_cnt      <= ones_cnt_d;
      d_out_q       <= d_out_d;
      d_valid_q     <= d_valid_d;
      pkt_start_q   <= pkt_start_d;
      pkt_end_q     <= pkt_end_d;
      stuff_error_q <= stuff_error_d;
    end
  end

  // Counts alongside d_valid so bit_count and the bit it covers appear
  // together; holds at all-ones rather than wrapping.
  rc_nrzi_unstuff_counter #(
    .W (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_inc & ~(&bit_count)),
    .q     (bit_count)
  );

  assign bus.d_out       = d_out_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.pkt_start   = pkt_start_q;
  assign bus.pkt_end     = pkt_end_q;
  assign bus.stuff_error = stuff_error_q;
  assign bus.bit_count   = bit_count;

endmodule

// File: tb/tb_rc_nrzi_unstuff.sv
// ---------------------------------------------------------------------------
// tb_rc_nrzi_unstuff
//   Self-checking bench for rc_nrzi_unstuff. Each vector holds one cycle of
//   line-side inputs plus the framing outputs expected after that clock
//   edge; decoded bits go to a queue and are matched by a d_valid monitor.
// ---------------------------------------------------------------------------
module tb_rc_nrzi_unstuff;
  import usb_rx_pkg::*;

  localparam int   CW = 7;
  localparam logic K  = LVL_K;
  localparam logic J  = LVL_J;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rc_nrzi_unstuff_if #(.CNT_W(CW)) bus ();

  rc_nrzi_unstuff #(
    .STUFF_LIMIT (6),
    .CNT_W       (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          valid;
    logic          pstart;
    logic          pend;
    logic          serr;
    logic [CW-1:0] cnt;
  } frame_t;

  typedef struct {
    logic   abort;
    logic   start;
    logic   eop;
    logic   err;
    logic   s;
    frame_t exp;
    logic   ebit;
  } vec_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  frame_t exp_q[$];
  logic   bit_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic frame_t fr(logic v, logic ps, logic pe, logic se, int c);
    frame_t f;
    f.valid  = v;
    f.pstart = ps;
    f.pend   = pe;
    f.serr   = se;
    f.cnt    = CW'(c);
    return f;
  endfunction

  function automatic vec_t mk(logic a, logic st, logic e, logic er, logic s, frame_t f, logic b);
    vec_t v;
    v.abort = a;
    v.start = st;
    v.eop   = e;
    v.err   = er;
    v.s     = s;
    v.exp   = f;
    v.ebit  = b;
    return v;
  endfunction

  // Shorthands for the common cycle kinds.
  function automatic vec_t start_v();
    return mk(0, 1, 0, 0, K, fr(0, 1, 0, 0, 0), 0);
  endfunction

  function automatic vec_t eop_v(int c);
    return mk(0, 0, 1, 0, K, fr(0, 0, 1, 0, c), 0);
  endfunction

  function automatic vec_t idle_v(int c, logic se);
    return mk(0, 0, 0, 0, K, fr(0, 0, 0, se, c), 0);
  endfunction

  function automatic vec_t abort_v();
    return mk(1, 0, 0, 0, K, fr(0, 0, 0, 0, 0), 0);
  endfunction

  function automatic vec_t ln(logic s, logic v, logic b, int c, logic se);
    return mk(0, 0, 0, 0, s, fr(v, 0, 0, se, c), b);
  endfunction

  function automatic frame_t sample();
    frame_t f;
    f.valid  = bus.d_valid;
    f.pstart = bus.pkt_start;
    f.pend   = bus.pkt_end;
    f.serr   = bus.stuff_error;
    f.cnt    = bus.bit_count;
    return f;
  endfunction

  task automatic step(input vec_t v, input string name);
    frame_t want;
    @(negedge clk);
    bus.abort         = v.abort;
    bus.start_rc_nrzi = v.start;
    bus.end_rc_nrzi   = v.eop;
    bus.dpdm_error    = v.err;
    bus.s_in          = v.s;
    exp_q.push_back(v.exp);
    if (v.exp.valid) bit_q.push_back(v.ebit);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(name, 32'(sample()), 32'(want));
  endtask

  task automatic run(input vec_t tbl[$], input string name);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s[%0d]", name, i));
  endtask

  // Decoded-bit scoreboard: every d_valid must match the next queued bit.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.d_valid) begin
      if (bit_q.size() == 0) check("d_valid_unexpected", 32'(bus.d_valid), 32'(0));
      else check("d_out", 32'(bus.d_out), 32'(bit_q.pop_front()));
    end
  end

  // Sends n decoded bits of pattern 1,1,0,... (never reaches the stuffing
  // limit) by NRZI-encoding them onto the line; bit_count expected to
  // saturate at all-ones.
  task automatic long_run(input int n, input string name);
    logic lvl;
    logic d;
    logic s;
    int   c;
    lvl = K;
    for (int i = 0; i < n; i++) begin
      d   = (i % 3) != 2;
      s   = d ? lvl : ~lvl;
      lvl = s;
      c   = (i + 1 > 127) ? 127 : i + 1;
      step(ln(s, 1, d, c, 0), $sformatf("%s[%0d]", name, i));
    end
  endtask

  initial begin
    vec_t t[$];

    bus.abort         = 1'b0;
    bus.start_rc_nrzi = 1'b0;
    bus.end_rc_nrzi   = 1'b0;
    bus.dpdm_error    = 1'b0;
    bus.s_in          = K;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(sample()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(idle_v(0, 0), "idle_after_reset");

    // Basic decode: J,J,K,K,J after the SYNC K -> 0,1,0,1,0.
    t.delete();
    t.push_back(start_v());
    t.push_back(ln(J, 1, 0, 1, 0));
    t.push_back(ln(J, 1, 1, 2, 0));
    t.push_back(ln(K, 1, 0, 3, 0));
    t.push_back(ln(K, 1, 1, 4, 0));
    t.push_back(ln(J, 1, 0, 5, 0));
    t.push_back(eop_v(5));
    t.push_back(idle_v(5, 0));
    run(t, "basic");

    // Stuffed zero: five K repeats give six 1s with the SYNC 1; the J
    // transition is the stuffed 0 and is dropped; a following K is a real 0.
    t.delete();
    t.push_back(start_v());
    for (int i = 1; i <= 5; i++) t.push_back(ln(K, 1, 1, i, 0));
    t.push_back(ln(J, 0, 0, 5, 0));
    t.push_back(ln(K, 1, 0, 6, 0));
    t.push_back(eop_v(6));
    run(t, "stuff_drop");

    // EOP while a stuffed bit is pending is a clean end.
    t.delete();
    t.push_back(start_v());
    for (int i = 1; i <= 5; i++) t.push_back(ln(K, 1, 1, i, 0));
    t.push_back(eop_v(5));
    t.push_back(idle_v(5, 0));
    run(t, "eop_at_limit");

    // Violation on the 6th K; error held 10 clks (start ignored), abort clears.
    t.delete();
    t.push_back(start_v());
    for (int i = 1; i <= 5; i++) t.push_back(ln(K, 1, 1, i, 0));
    t.push_back(ln(K, 0, 0, 5, 1));
    for (int i = 0; i < 10; i++) begin
      if (i == 4) t.push_back(mk(0, 1, 0, 0, K, fr(0, 0, 0, 1, 5), 0));
      else t.push_back(ln((i % 2) ? J : K, 0, 0, 5, 1));
    end
    t.push_back(abort_v());
    t.push_back(idle_v(0, 0));
    run(t, "stuff_err");

    // dpdm_error after 3 bits: no pkt_end, count holds until the next start.
    t.delete();
    t.push_back(start_v());
    t.push_back(ln(J, 1, 0, 1, 0));
    t.push_back(ln(K, 1, 0, 2, 0));
    t.push_back(ln(J, 1, 0, 3, 0));
    t.push_back(mk(0, 0, 0, 1, K, fr(0, 0, 0, 0, 3), 0));
    t.push_back(idle_v(3, 0));
    t.push_back(ln(J, 0, 0, 3, 0));
    t.push_back(ln(K, 0, 0, 3, 0));
    t.push_back(start_v());
    t.push_back(abort_v());
    run(t, "line_err");

    // abort with start: stay idle, line bits produce nothing.
    t.delete();
    t.push_back(mk(1, 1, 0, 0, K, fr(0, 0, 0, 0, 0), 0));
    t.push_back(ln(J, 0, 0, 0, 0));
    t.push_back(ln(K, 0, 0, 0, 0));
    t.push_back(ln(K, 0, 0, 0, 0));
    run(t, "abort_start");

    // Start while active restarts the packet.
    t.delete();
    t.push_back(start_v());
    t.push_back(ln(J, 1, 0, 1, 0));
    t.push_back(ln(J, 1, 1, 2, 0));
    t.push_back(start_v());
    t.push_back(ln(J, 1, 0, 1, 0));
    t.push_back(eop_v(1));
    run(t, "restart");

    // Full 101-bit payload, then a 130-bit run that saturates the count.
    step(start_v(), "p101_start");
    long_run(101, "p101");
    step(eop_v(101), "p101_eop");

    step(start_v(), "sat_start");
    long_run(130, "sat");
    step(eop_v(127), "sat_eop");

    // Async reset mid-packet: outputs clear at once, no pkt_end follows.
    step(start_v(), "rst_start");
    step(ln(J, 1, 0, 1, 0), "rst_bit");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(sample()), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(idle_v(0, 0), "after_reset");
    step(idle_v(0, 0), "after_reset2");

    check("bit_queue_empty", 32'(bit_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
